// File: rtl/inst_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for the instruction decode stage.
// The master side feeds words and consumes decoded entries; the slave side is the decoder.
interface inst_decode_stage_if #(
  parameter int PC_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_word;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            skip_req;
  logic            out_valid;
  logic            out_ready;
  logic [82:0]     out_decode;
  logic [15:0]     out_ir;
  logic [15:0]     out_k;
  logic [PC_W-1:0] out_pc;
  logic            out_two_word;
  logic            out_illegal;

  modport master (
    output in_valid, in_word, in_pc, flush, skip_req, out_ready,
    input  in_ready, out_valid, out_decode, out_ir, out_k, out_pc, out_two_word, out_illegal
  );

  modport slave (
    input  in_valid, in_word, in_pc, flush, skip_req, out_ready,
    output in_ready, out_valid, out_decode, out_ir, out_k, out_pc, out_two_word, out_illegal
  );
endinterface

// File: rtl/inst_decode_stage.sv
// AVR-style instruction decode stage: pairs two-word instructions, applies skip squashing,
// and presents a one-hot opcode vector through a single-entry output register.
module inst_decode_stage #(
  parameter bit MUL_EN  = 1'b1,
  parameter bit LPMX_EN = 1'b1,
  parameter bit SPM_EN  = 1'b1,
  parameter int PC_W    = 16
) (
  input logic clk,
  input logic rst,
  inst_decode_stage_if.slave bus
);
  localparam int N_OP = 83;

  localparam logic [0:0] ST_FIRST  = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  localparam logic [6:0] OP_MULS    = 7'd2;
  localparam logic [6:0] OP_FMULSU  = 7'd6;
  localparam logic [6:0] OP_LDS     = 7'd25;
  localparam logic [6:0] OP_LPM_Z   = 7'd28;
  localparam logic [6:0] OP_LPM_ZP  = 7'd29;
  localparam logic [6:0] OP_STS     = 7'd36;
  localparam logic [6:0] OP_JMP     = 7'd53;
  localparam logic [6:0] OP_CALL    = 7'd54;
  localparam logic [6:0] OP_SPM     = 7'd62;
  localparam logic [6:0] OP_MUL     = 7'd71;

  logic [0:0]      state;
  logic            skip_pend;
  logic [6:0]      op_idx;
  logic            op_hit;
  logic            feature_off;
  logic            illegal;
  logic            two_word_op;
  logic [N_OP-1:0] decode_vec;
  logic            ready;
  logic            accept;
  logic            complete;
  logic            emit;

  logic [15:0]     hold_ir;
  logic [PC_W-1:0] hold_pc;
  logic [N_OP-1:0] hold_decode;

  logic            res_valid;
  logic [N_OP-1:0] res_decode;
  logic [15:0]     res_ir;
  logic [15:0]     res_k;
  logic [PC_W-1:0] res_pc;
  logic            res_two_word;
  logic            res_illegal;

  // Opcode number table in priority order; the casez takes the first matching row.
  always_comb begin
    op_hit = 1'b1;
    op_idx = 7'd0;
    casez (bus.in_word)
      16'b0000_0000_0000_0000: op_idx = 7'd0;
      16'b0000_0001_????_????: op_idx = 7'd1;
      16'b0000_0010_????_????: op_idx = 7'd2;
      16'b0000_0011_0???_0???: op_idx = 7'd3;
      16'b0000_0011_0???_1???: op_idx = 7'd4;
      16'b0000_0011_1???_0???: op_idx = 7'd5;
      16'b0000_0011_1???_1???: op_idx = 7'd6;
      16'b0000_01??_????_????: op_idx = 7'd7;
      16'b0000_10??_????_????: op_idx = 7'd8;
      16'b0000_11??_????_????: op_idx = 7'd9;
      16'b0001_00??_????_????: op_idx = 7'd10;
      16'b0001_01??_????_????: op_idx = 7'd11;
      16'b0001_10??_????_????: op_idx = 7'd12;
      16'b0001_11??_????_????: op_idx = 7'd13;
      16'b0010_00??_????_????: op_idx = 7'd14;
      16'b0010_01??_????_????: op_idx = 7'd15;
      16'b0010_10??_????_????: op_idx = 7'd16;
      16'b0010_11??_????_????: op_idx = 7'd17;
      16'b0011_????_????_????: op_idx = 7'd18;
      16'b0100_????_????_????: op_idx = 7'd19;
      16'b0101_????_????_????: op_idx = 7'd20;
      16'b0110_????_????_????: op_idx = 7'd21;
      16'b0111_????_????_????: op_idx = 7'd22;
      16'b10?0_??0?_????_????: op_idx = 7'd23;
      16'b10?0_??1?_????_????: op_idx = 7'd24;
      16'b1001_000?_????_0000: op_idx = 7'd25;
      16'b1001_000?_????_0001: op_idx = 7'd26;
      16'b1001_000?_????_0010: op_idx = 7'd27;
      16'b1001_000?_????_0100: op_idx = 7'd28;
      16'b1001_000?_????_0101: op_idx = 7'd29;
      16'b1001_000?_????_1001: op_idx = 7'd30;
      16'b1001_000?_????_1010: op_idx = 7'd31;
      16'b1001_000?_????_1100: op_idx = 7'd32;
      16'b1001_000?_????_1101: op_idx = 7'd33;
      16'b1001_000?_????_1110: op_idx = 7'd34;
      16'b1001_000?_????_1111: op_idx = 7'd35;
      16'b1001_001?_????_0000: op_idx = 7'd36;
      16'b1001_001?_????_0001: op_idx = 7'd37;
      16'b1001_001?_????_0010: op_idx = 7'd38;
      16'b1001_001?_????_1001: op_idx = 7'd39;
      16'b1001_001?_????_1010: op_idx = 7'd40;
      16'b1001_001?_????_1100: op_idx = 7'd41;
      16'b1001_001?_????_1101: op_idx = 7'd42;
      16'b1001_001?_????_1110: op_idx = 7'd43;
      16'b1001_001?_????_1111: op_idx = 7'd44;
      16'b1001_010?_????_0000: op_idx = 7'd45;
      16'b1001_010?_????_0001: op_idx = 7'd46;
      16'b1001_010?_????_0010: op_idx = 7'd47;
      16'b1001_010?_????_0011: op_idx = 7'd48;
      16'b1001_010?_????_0101: op_idx = 7'd49;
      16'b1001_010?_????_0110: op_idx = 7'd50;
      16'b1001_010?_????_0111: op_idx = 7'd51;
      16'b1001_010?_????_1010: op_idx = 7'd52;
      16'b1001_010?_????_110?: op_idx = 7'd53;
      16'b1001_010?_????_111?: op_idx = 7'd54;
      16'b1001_0100_0???_1000: op_idx = 7'd55;
      16'b1001_0100_1???_1000: op_idx = 7'd56;
      16'b1001_0101_0000_1000: op_idx = 7'd57;
      16'b1001_0101_0001_1000: op_idx = 7'd58;
      16'b1001_0101_1000_1000: op_idx = 7'd59;
      16'b1001_0101_1010_1000: op_idx = 7'd60;
      16'b1001_0101_1100_1000: op_idx = 7'd61;
      16'b1001_0101_1110_1000: op_idx = 7'd62;
      16'b1001_0100_0000_1001: op_idx = 7'd63;
      16'b1001_0101_0000_1001: op_idx = 7'd64;
      16'b1001_0110_????_????: op_idx = 7'd65;
      16'b1001_0111_????_????: op_idx = 7'd66;
      16'b1001_1000_????_????: op_idx = 7'd67;
      16'b1001_1001_????_????: op_idx = 7'd68;
      16'b1001_1010_????_????: op_idx = 7'd69;
      16'b1001_1011_????_????: op_idx = 7'd70;
      16'b1001_11??_????_????: op_idx = 7'd71;
      16'b1011_0???_????_????: op_idx = 7'd72;
      16'b1011_1???_????_????: op_idx = 7'd73;
      16'b1100_????_????_????: op_idx = 7'd74;
      16'b1101_????_????_????: op_idx = 7'd75;
      16'b1110_????_????_????: op_idx = 7'd76;
      16'b1111_00??_????_????: op_idx = 7'd77;
      16'b1111_01??_????_????: op_idx = 7'd78;
      16'b1111_100?_????_0???: op_idx = 7'd79;
      16'b1111_101?_????_0???: op_idx = 7'd80;
      16'b1111_110?_????_0???: op_idx = 7'd81;
      16'b1111_111?_????_0???: op_idx = 7'd82;
      default:                 op_hit = 1'b0;
    endcase
  end

  // Disabled optional features turn their encodings into illegal instructions.
  always_comb begin
    feature_off = (!MUL_EN && ((op_idx >= OP_MULS && op_idx <= OP_FMULSU) || op_idx == OP_MUL)) ||
                  (!LPMX_EN && (op_idx == OP_LPM_Z || op_idx == OP_LPM_ZP)) ||
                  (!SPM_EN && op_idx == OP_SPM);
    illegal     = !op_hit || feature_off;
    two_word_op = op_hit && (op_idx == OP_LDS || op_idx == OP_STS ||
                             op_idx == OP_JMP || op_idx == OP_CALL);
    decode_vec  = illegal ? '0 : ({{(N_OP-1){1'b0}}, 1'b1} << op_idx);
  end

  assign ready    = !bus.flush && (!res_valid || bus.out_ready);
  assign accept   = bus.in_valid && ready;
  assign complete = accept && (state == ST_SECOND || !two_word_op);
  assign emit     = complete && !skip_pend;

  // Squash state is judged when an instruction completes, so both words of a skipped pair vanish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FIRST;
      skip_pend    <= 1'b0;
      hold_ir      <= '0;
      hold_pc      <= '0;
      hold_decode  <= '0;
      res_valid    <= 1'b0;
      res_decode   <= '0;
      res_ir       <= '0;
      res_k        <= '0;
      res_pc       <= '0;
      res_two_word <= 1'b0;
      res_illegal  <= 1'b0;
    end else if (bus.flush) begin
      state     <= ST_FIRST;
      skip_pend <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (state == ST_FIRST && two_word_op) begin
          state       <= ST_SECOND;
          hold_ir     <= bus.in_word;
          hold_pc     <= bus.in_pc;
          hold_decode <= decode_vec;
        end else if (state == ST_SECOND) begin
          state <= ST_FIRST;
        end
      end
      if (skip_pend) begin
        if (complete) skip_pend <= 1'b0;
      end else if (bus.skip_req) begin
        skip_pend <= 1'b1;
      end
      if (emit) begin
        res_valid <= 1'b1;
        if (state == ST_SECOND) begin
          res_decode   <= hold_decode;
          res_ir       <= hold_ir;
          res_k        <= bus.in_word;
          res_pc       <= hold_pc;
          res_two_word <= 1'b1;
          res_illegal  <= 1'b0;
        end else begin
          res_decode   <= decode_vec;
          res_ir       <= bus.in_word;
          res_k        <= '0;
          res_pc       <= bus.in_pc;
          res_two_word <= 1'b0;
          res_illegal  <= illegal;
        end
      end else if (bus.out_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = res_valid;
  assign bus.out_decode   = res_decode;
  assign bus.out_ir       = res_ir;
  assign bus.out_k        = res_k;
  assign bus.out_pc       = res_pc;
  assign bus.out_two_word = res_two_word;
  assign bus.out_illegal  = res_illegal;
endmodule

// File: doc/inst_decode_stage.md
INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

Interface
REQ-001 Parameter MUL_EN, default 1: enables the MUL/MULS/MULSU/FMUL/FMULS/FMULSU decode; when 0 these encodings are illegal.
REQ-002 Parameter LPMX_EN, default 1: enables LPM Rd,Z and LPM Rd,Z+; when 0 these encodings are illegal.
REQ-003 Parameter SPM_EN, default 1: enables SPM; when 0 SPM is illegal.
REQ-004 Parameter PC_W, default 16: width of the word-address program counter.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_valid  in  1  the fetch word is valid.
REQ-009 in_ready  out  1  the fetch word is accepted when in_valid & in_ready.
REQ-010 in_word  in  16  the instruction word (first or second word).
REQ-011 in_pc  in  PC_W  the word address of in_word.
REQ-012 flush  in  1  discard pending and held state (branch taken / interrupt).
REQ-013 skip_req  in  1  single-cycle pulse: squash the next whole instruction.
REQ-014 out_valid  out  1  a decoded instruction is presented.
REQ-015 out_ready  in  1  the consumer accepts the presented instruction.
REQ-016 out_decode  out  83  one-hot opcode vector; bit index per the team opcode number table.
REQ-017 out_ir  out  16  the first instruction word.
REQ-018 out_k  out  16  the second word for two-word instructions, else 0.
REQ-019 out_pc  out  PC_W  the address of the first word.
REQ-020 out_two_word  out  1  the instruction is JMP, CALL, LDS or STS.
REQ-021 out_illegal  out  1  no enabled pattern matched; out_decode is all zero.

Function
REQ-022 Decode of the first word: match against the team opcode patterns in table priority order; the first match sets its bit; disabled-feature matches force illegal.
REQ-023 FSM states:
- FIRST: expecting the first word.
- SECOND: expecting the second word of JMP/CALL/LDS/STS.
REQ-024 FSM transitions:
- FIRST -> SECOND when an accepted first word is two-word.
- SECOND -> FIRST when the second word is accepted.
- Otherwise the state holds.
REQ-025 Output register: a single-entry output register holds {decode, ir, k, pc, two_word, illegal}; in_ready = !flush & (!out_valid | out_ready).
REQ-026 Latency, single-word instruction: an accepted single-word instruction appears with out_valid=1 on the next cycle.
REQ-027 Latency, two-word instruction: appears one cycle after its second word is accepted; nothing is emitted for the first word alone.
REQ-028 Backpressure: while out_valid & !out_ready, all out_* hold stable and no word is accepted.
REQ-029 Simultaneous load and drain: out_valid & out_ready with a new emit in the same cycle loads the new entry with no bubble; with no new emit, out_valid falls.
REQ-030 skip_req sets skip_pend.
REQ-031 Squash: the next instruction accepted while skip_pend=1 is consumed but not emitted; for a two-word instruction both words are consumed.
REQ-032 skip_pend clears when the squashed instruction completes.
REQ-033 skip_req while skip_pend=1 has no additional effect (no accumulation).
REQ-034 Flush effect: flush clears out_valid and skip_pend, forces state FIRST, and accepts no word that cycle.
REQ-035 Flush priority: flush has priority over skip_req, in_valid and out_ready in the same cycle.
REQ-036 Illegal instructions are emitted as normal single-word entries with out_illegal=1 and out_k=0.

Reset
REQ-037 On rst: state=FIRST, skip_pend=0, out_valid=0, and out_decode, out_ir, out_k, out_pc, out_two_word and out_illegal = 0.
REQ-038 rst mid-operation (in SECOND or with a held entry): pending data is discarded with no emit; in_ready=1 on the first cycle after rst deasserts.

Verification
REQ-039 Single-word: in_word=0x0C01 (ADD), in_pc=0x0010, out_ready=1 -> next cycle out_valid=1, only the ADD bit is set, out_pc=0x0010, out_k=0, out_two_word=0.
REQ-040 Two-word: JMP 0x940C at pc 0x0020, then 0x1234 -> no emit after the first word; after the second, JMP bit set, out_k=0x1234, out_pc=0x0020, out_two_word=1.
REQ-041 Skip: skip_req pulse, then LDS 0x9100,0x0200, then NOP 0x0000 -> only NOP is emitted; skip_pend=0 afterwards.
REQ-042 Backpressure: out_ready=0 for 3 cycles with 0x2C01 (MOV) held -> out_* stable and in_ready=0; release -> next word accepted the same cycle.
REQ-043 Feature mask: MUL_EN=0, in_word=0x9C00 -> out_illegal=1 and out_decode=0; with MUL_EN=1 -> MUL bit set.
REQ-044 Flush: flush in SECOND after CALL 0x940E -> no emit; the next word 0x0000 is decoded as NOP from state FIRST.
